branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor_pkg.sv | 15 +
 rtl/branch_predictor_sat_counter2.sv | 21 ++
 rtl/branch_predictor.sv | 94 +++++++++
 tb/tb_branch_predictor.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared pipeline package: 2-bit counter encodings and branch predictor sizing.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_state_t;

    localparam int unsigned BHT_DEPTH = 16;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned STAT_W    = 16;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating counter next-state logic: step toward taken or not-taken, clamp at the ends.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  ctr_state_t state,
    input  logic       taken,
    output ctr_state_t next_state
);

    always_comb begin
        next_state = state;
        case (state)
            STRONG_NT: next_state = taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   next_state = taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    next_state = taken ? STRONG_T : WEAK_NT;
            STRONG_T:  next_state = taken ? STRONG_T : WEAK_T;
            default:   next_state = WEAK_NT;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Decode-stage branch predictor with EX-stage resolution and recovery.
// Define BRPRED_BHT_EN for a 16-entry table indexed by PC[5:2]; otherwise one global counter.
module branch_predictor
    import branch_predictor_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              iBranch_RegD,
    input  logic [31:0]       iPC_RegD,
    input  logic              iBranch_RegE,
    input  logic              izero_RegE,
    input  logic [31:0]       iPCplus4_RegE,
    input  logic [31:0]       iTarget_RegE,
    input  logic              iStall_dec,
    output logic [1:0]        obranch_predict,
    output logic [31:0]       oRecoverPC,
    output logic [STAT_W-1:0] oBranchCnt,
    output logic [STAT_W-1:0] oMissCnt
);

`ifdef BRPRED_BHT_EN
    localparam int unsigned NUM_CTR = BHT_DEPTH;
`else
    localparam int unsigned NUM_CTR = 1;
`endif

    ctr_state_t       bht [NUM_CTR];
    ctr_state_t       lookup;
    ctr_state_t       ctr_cur;
    ctr_state_t       ctr_next;
    logic [IDX_W-1:0] idx_d;
    logic [IDX_W-1:0] idx_e;
    logic             valid_e;
    logic             pred_e;
    logic             pred_d;
    logic             mispredict;
    logic             update;
    logic             unused_pc;

`ifdef BRPRED_BHT_EN
    assign idx_d     = iPC_RegD[5:2];
    assign lookup    = bht[idx_d];
    assign ctr_cur   = bht[idx_e];
    assign unused_pc = ^{iPC_RegD[31:6], iPC_RegD[1:0]};
`else
    assign idx_d     = '0;
    assign lookup    = bht[0];
    assign ctr_cur   = bht[0];
    assign unused_pc = ^iPC_RegD;
`endif

    assign pred_d     = (lookup == WEAK_T) || (lookup == STRONG_T);
    assign update     = iBranch_RegE & valid_e;
    assign mispredict = update & (pred_e != izero_RegE);

    assign obranch_predict = {mispredict, iBranch_RegD & pred_d & ~mispredict};
    assign oRecoverPC      = izero_RegE ? iTarget_RegE : iPCplus4_RegE;

    sat_counter2 u_sat (
        .state      (ctr_cur),
        .taken      (izero_RegE),
        .next_state (ctr_next)
    );

    // Lookup reads the array directly, so a same-cycle update is not bypassed.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CTR; i++) begin
                bht[i] <= WEAK_NT;
            end
            valid_e    <= 1'b0;
            pred_e     <= 1'b0;
            idx_e      <= '0;
            oBranchCnt <= '0;
            oMissCnt   <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CTR; i++) begin
                if (update && (idx_e == IDX_W'(i))) begin
                    bht[i] <= ctr_next;
                end
            end
            valid_e <= iBranch_RegD & ~iStall_dec & ~mispredict;
            pred_e  <= pred_d;
            idx_e   <= idx_d;
            if (update) begin
                oBranchCnt <= oBranchCnt + 1'b1;
            end
            if (mispredict) begin
                oMissCnt <= oMissCnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (expectations follow BRPRED_BHT_EN when defined).
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        iBranch_RegD;
    logic [31:0] iPC_RegD;
    logic        iBranch_RegE;
    logic        izero_RegE;
    logic [31:0] iPCplus4_RegE;
    logic [31:0] iTarget_RegE;
    logic        iStall_dec;
    logic [1:0]  obranch_predict;
    logic [31:0] oRecoverPC;
    logic [15:0] oBranchCnt;
    logic [15:0] oMissCnt;

    int tests_run = 0;
    int fails     = 0;

    branch_predictor dut (
        .clk             (clk),
        .rst             (rst),
        .iBranch_RegD    (iBranch_RegD),
        .iPC_RegD        (iPC_RegD),
        .iBranch_RegE    (iBranch_RegE),
        .izero_RegE      (izero_RegE),
        .iPCplus4_RegE   (iPCplus4_RegE),
        .iTarget_RegE    (iTarget_RegE),
        .iStall_dec      (iStall_dec),
        .obranch_predict (obranch_predict),
        .oRecoverPC      (oRecoverPC),
        .oBranchCnt      (oBranchCnt),
        .oMissCnt        (oMissCnt)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic bd, input logic [31:0] pc, input logic be, input logic z,
                         input logic [31:0] p4, input logic [31:0] tgt, input logic stall);
        iBranch_RegD  = bd;
        iPC_RegD      = pc;
        iBranch_RegE  = be;
        izero_RegE    = z;
        iPCplus4_RegE = p4;
        iTarget_RegE  = tgt;
        iStall_dec    = stall;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (oBranchCnt !== 16'd0 || oMissCnt !== 16'd0) begin
            fails++;
            $display("FAIL reset_stats: got br=%0d miss=%0d expected 0/0", oBranchCnt, oMissCnt);
        end
        // Branch in EX right after reset has no valid shadow; ID branch sees WEAK_NT.
        drive(1'b1, 32'h40, 1'b1, 1'b0, 32'h44, 32'h100, 1'b0);
        tests_run++;
        if (obranch_predict !== 2'b00) begin
            fails++;
            $display("FAIL reset_predict: got %b expected 00", obranch_predict);
        end
        tick();
        idle();
        tick();
        tests_run++;
        if (oBranchCnt !== 16'd0 || oMissCnt !== 16'd0) begin
            fails++;
            $display("FAIL reset_no_update: got br=%0d miss=%0d expected 0/0", oBranchCnt, oMissCnt);
        end
    endtask

    task automatic test_weak_nt_taken();
        drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tests_run++;
        if (obranch_predict !== 2'b00) begin
            fails++;
            $display("FAIL wnt_fetch: got %b expected 00", obranch_predict);
        end
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h44, 32'h100, 1'b0);
        tests_run++;
        if (obranch_predict !== 2'b10 || oRecoverPC !== 32'h100) begin
            fails++;
            $display("FAIL wnt_miss: got %b pc=%h expected 10 pc=00000100", obranch_predict, oRecoverPC);
        end
        tick();
        idle();
        tests_run++;
        if (oBranchCnt !== 16'd1 || oMissCnt !== 16'd1) begin
            fails++;
            $display("FAIL wnt_stats: got br=%0d miss=%0d expected 1/1", oBranchCnt, oMissCnt);
        end
    endtask

    task automatic test_train();
        for (int r = 0; r < 2; r++) begin
            drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            tests_run++;
            if (obranch_predict !== 2'b01) begin
                fails++;
                $display("FAIL train_fetch%0d: got %b expected 01", r, obranch_predict);
            end
            tick();
            drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h44, 32'h100, 1'b0);
            tests_run++;
            if (obranch_predict !== 2'b00) begin
                fails++;
                $display("FAIL train_resolve%0d: got %b expected 00", r, obranch_predict);
            end
            tick();
        end
        idle();
        tests_run++;
        if (oBranchCnt !== 16'd3 || oMissCnt !== 16'd1) begin
            fails++;
            $display("FAIL train_stats: got br=%0d miss=%0d expected 3/1", oBranchCnt, oMissCnt);
        end
    endtask

    task automatic test_strong_t_miss();
        drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tests_run++;
        if (obranch_predict !== 2'b01) begin
            fails++;
            $display("FAIL st_fetch: got %b expected 01", obranch_predict);
        end
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h48, 32'h200, 1'b0);
        tests_run++;
        if (obranch_predict !== 2'b10 || oRecoverPC !== 32'h48) begin
            fails++;
            $display("FAIL st_miss: got %b pc=%h expected 10 pc=00000048", obranch_predict, oRecoverPC);
        end
        tick();
        idle();
        tests_run++;
        if (oBranchCnt !== 16'd4 || oMissCnt !== 16'd2) begin
            fails++;
            $display("FAIL st_stats: got br=%0d miss=%0d expected 4/2", oBranchCnt, oMissCnt);
        end
    endtask

    task automatic test_stall();
        // Counter is WEAK_T: one decrement from STRONG_T.
        drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        tests_run++;
        if (obranch_predict !== 2'b01) begin
            fails++;
            $display("FAIL stall_fetch: got %b expected 01", obranch_predict);
        end
        tick();
        // Bubble in EX carries iBranch_RegE=1 but valid_E=0: no mispredict, no update.
        drive(1'b1, 32'h40, 1'b1, 1'b0, 32'h44, 32'h100, 1'b0);
        tests_run++;
        if (obranch_predict !== 2'b01) begin
            fails++;
            $display("FAIL stall_bubble: got %b expected 01", obranch_predict);
        end
        tick();
        tests_run++;
        if (oBranchCnt !== 16'd4 || oMissCnt !== 16'd2) begin
            fails++;
            $display("FAIL stall_no_update: got br=%0d miss=%0d expected 4/2", oBranchCnt, oMissCnt);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h44, 32'h100, 1'b0);
        tests_run++;
        if (obranch_predict !== 2'b00) begin
            fails++;
            $display("FAIL stall_resolve: got %b expected 00", obranch_predict);
        end
        tick();
        idle();
        tests_run++;
        if (oBranchCnt !== 16'd5 || oMissCnt !== 16'd2) begin
            fails++;
            $display("FAIL stall_stats: got br=%0d miss=%0d expected 5/2", oBranchCnt, oMissCnt);
        end
    endtask

    task automatic test_squash();
        // Counter is STRONG_T.
        drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        drive(1'b1, 32'h40, 1'b1, 1'b0, 32'h44, 32'h100, 1'b0);
        tests_run++;
        if (obranch_predict !== 2'b10 || oRecoverPC !== 32'h44) begin
            fails++;
            $display("FAIL squash_miss: got %b pc=%h expected 10 pc=00000044", obranch_predict, oRecoverPC);
        end
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h44, 32'h100, 1'b0);
        tests_run++;
        if (obranch_predict !== 2'b00) begin
            fails++;
            $display("FAIL squash_ex: got %b expected 00", obranch_predict);
        end
        tick();
        tests_run++;
        if (oBranchCnt !== 16'd6 || oMissCnt !== 16'd3) begin
            fails++;
            $display("FAIL squash_stats: got br=%0d miss=%0d expected 6/3", oBranchCnt, oMissCnt);
        end
        drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tests_run++;
        if (obranch_predict !== 2'b01) begin
            fails++;
            $display("FAIL squash_ctr: got %b expected 01", obranch_predict);
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        rst = 1'b0;
        drive(1'b1, 32'h40, 1'b1, 1'b1, 32'h44, 32'h100, 1'b0);
        tests_run++;
        if (obranch_predict !== 2'b00 || oBranchCnt !== 16'd0 || oMissCnt !== 16'd0) begin
            fails++;
            $display("FAIL mid_reset: got %b br=%0d miss=%0d expected 00 0/0", obranch_predict, oBranchCnt, oMissCnt);
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_sat_low();
        for (int r = 0; r < 2; r++) begin
            drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            tick();
            drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h44, 32'h100, 1'b0);
            tests_run++;
            if (obranch_predict !== 2'b00) begin
                fails++;
                $display("FAIL satlo_nt%0d: got %b expected 00", r, obranch_predict);
            end
            tick();
        end
        // STRONG_NT + one taken -> WEAK_NT, still predicts not-taken.
        drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h44, 32'h100, 1'b0);
        tests_run++;
        if (obranch_predict !== 2'b10) begin
            fails++;
            $display("FAIL satlo_taken: got %b expected 10", obranch_predict);
        end
        tick();
        drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tests_run++;
        if (obranch_predict !== 2'b00) begin
            fails++;
            $display("FAIL satlo_floor: got %b expected 00", obranch_predict);
        end
        tick();
        idle();
        tick();
        tests_run++;
        if (oBranchCnt !== 16'd3 || oMissCnt !== 16'd1) begin
            fails++;
            $display("FAIL satlo_stats: got br=%0d miss=%0d expected 3/1", oBranchCnt, oMissCnt);
        end
    endtask

    task automatic test_bht();
        logic [1:0] exp_48;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            drive(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            tick();
            drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h48, 32'h100, 1'b0);
            tick();
        end
        drive(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tests_run++;
        if (obranch_predict !== 2'b01) begin
            fails++;
            $display("FAIL bht_pc44: got %b expected 01", obranch_predict);
        end
        tick();
        idle();
        tick();
`ifdef BRPRED_BHT_EN
        exp_48 = 2'b00;
`else
        exp_48 = 2'b01;
`endif
        drive(1'b1, 32'h48, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tests_run++;
        if (obranch_predict !== exp_48) begin
            fails++;
            $display("FAIL bht_pc48: got %b expected %b", obranch_predict, exp_48);
        end
        tick();
        idle();
        tick();
        tests_run++;
        if (oBranchCnt !== 16'd2 || oMissCnt !== 16'd1) begin
            fails++;
            $display("FAIL bht_stats: got br=%0d miss=%0d expected 2/1", oBranchCnt, oMissCnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_weak_nt_taken();
        test_train();
        test_strong_t_miss();
        test_stall();
        test_squash();
        test_mid_reset();
        test_sat_low();
        test_bht();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
